full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
Registered full adder: adds operands In1, In2 and carry-in Cin, then presents Sum and Cout one clock later.
The default width is 1 bit, a single-bit full adder. The operands can be widened to a WIDTH-bit ripple-carry adder built from 1-bit slices.
Used as the arithmetic leaf cell in datapath blocks. It also serves as the reference adder for exhaustive truth-table benches.

Parameters:
WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous assert, active-high; clears all output registers
In1  input  WIDTH  operand A, unsigned
In2  input  WIDTH  operand B, unsigned
Cin  input  1  carry-in to bit 0
in_valid  input  1  high when In1/In2/Cin carry a new operation to capture this cycle
Sum  output  WIDTH  registered sum bits, (In1 + In2 + Cin) mod 2^WIDTH
Cout  output  1  registered carry out of the MSB
Ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
out_valid  output  1  high for one cycle when Sum/Cout/Ovf hold the result of a captured operation

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, Sum=0, Cout=0, Ovf=0 and out_valid=0 immediately, without waiting for a clock edge. Deassertion is sampled on the next rising clk; the first capture can occur on the first rising edge with rst=0.
- Arithmetic is combinational: a ripple chain of WIDTH 1-bit slices.
  - Slice i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
  - c[0] = Cin; Cout = c[WIDTH].
  - Ovf = c[WIDTH-1] ^ c[WIDTH]. For WIDTH=1, c[0] is Cin, so Ovf = Cin ^ Cout.
- Capture: on a rising clk with in_valid=1, register the computed sum, carry and overflow, and set out_valid=1.
- Latency is exactly 1 cycle from the in_valid sample to valid outputs. Throughput is one operation per cycle with no stall; back-to-back in_valid is legal.
- When in_valid=0 at a rising edge:
  - Sum, Cout and Ovf hold their previous values.
  - out_valid goes to 0.
- Wrap-around: a result ≥ 2^WIDTH truncates into Sum, and the excess bit appears only on Cout. There is no saturation.
- Inputs are sampled only at the clock edge. Input changes between edges have no effect on the outputs.
- Reset asserted mid-operation:
  - The pending result is discarded.
  - Outputs clear asynchronously.
  - out_valid stays 0 until a fresh capture after reset deasserts.
- X on inputs while in_valid=0 must not propagate to the outputs.

Decomposition:
- Shared package full_adder_pkg:
  - constant FA_MAX_WIDTH = 64;
  - a typedef for the result record: sum, cout, ovf.
- Sub-module full_adder_bit: the purely combinational 1-bit slice (a, b, cin -> s, cout).
  - The top instantiates WIDTH copies in a generate loop.
  - The top adds the input-capture condition, the output registers and the valid flag.

Test Plan:
- WIDTH=1, exhaustive sweep with in_valid=1, one combination per cycle, {In1,In2,Cin} = 000..111. One cycle later {Cout,Sum} must read 00, 01, 01, 10, 01, 10, 10, 11.
- WIDTH=1, reset mid-stream: drive 1,1,1 with in_valid=1, then assert rst between edges. Sum, Cout and out_valid must be 0 immediately. After release, 0,1,0 yields Sum=1, Cout=0 one cycle later.
- WIDTH=4, wrap: In1=15, In2=0, Cin=1 -> Sum=0, Cout=1, Ovf=0. In1=15, In2=15, Cin=1 -> Sum=15, Cout=1, Ovf=0.
- WIDTH=4, signed overflow: In1=7, In2=1, Cin=0 -> Sum=8, Cout=0, Ovf=1. In1=8, In2=8, Cin=0 -> Sum=0, Cout=1, Ovf=1.
- Hold: capture 3+4+0 at WIDTH=4 (Sum=7), then drop in_valid and toggle the inputs for 5 cycles. Sum must stay 7 with Cout=0, and out_valid must be 1 for exactly one cycle.
- Back-to-back at WIDTH=8: capture 200+100+0 then 1+1+1 on consecutive cycles. The outputs must read Sum=44, Cout=1, then Sum=3, Cout=0, with out_valid high on both cycles.

Source files
------------

// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width limit and result record for the registered adder.
package full_adder_pkg;
   localparam int FA_MAX_WIDTH = 64;
   typedef struct packed {
      logic [FA_MAX_WIDTH-1:0] sum;
      logic                    cout;
      logic                    ovf;
   } fa_result_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full-adder slice.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with registered sum, carry, signed overflow and valid.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic             Cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic             out_valid
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   fa_result_t       res_d, res_q;
   logic             valid_d, valid_q;
   logic             unused_sum_hi;
   assign c[0] = Cin;
   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_bit (
         .a   (In1[i]),
         .b   (In2[i]),
         .cin (c[i]),
         .s   (s[i]),
         .cout(c[i+1])
      );
   end
   // Inputs are only looked at when in_valid is high, so X on idle inputs never reaches the registers.
   always_comb begin
      res_d   = res_q;
      valid_d = in_valid;
      if (in_valid) begin
         res_d.sum            = '0;
         res_d.sum[WIDTH-1:0] = s;
         res_d.cout           = c[WIDTH];
         res_d.ovf            = c[WIDTH-1] ^ c[WIDTH];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end
   assign Sum           = res_q.sum[WIDTH-1:0];
   assign Cout          = res_q.cout;
   assign Ovf           = res_q.ovf;
   assign out_valid     = valid_q;
   assign unused_sum_hi = ^res_q.sum;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and randomized checks of full_adder at WIDTH 1, 4 and 8.
module tb_full_adder;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [0:0] a1, b1, sum1;
   logic       ci1, v1, co1, of1, vo1;
   logic [3:0] a4, b4, sum4;
   logic       ci4, v4, co4, of4, vo4;
   logic [7:0] a8, b8, sum8;
   logic       ci8, v8, co8, of8, vo8;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .In1(a1), .In2(b1), .Cin(ci1), .in_valid(v1),
      .Sum(sum1), .Cout(co1), .Ovf(of1), .out_valid(vo1));
   full_adder #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .In1(a4), .In2(b4), .Cin(ci4), .in_valid(v4),
      .Sum(sum4), .Cout(co4), .Ovf(of4), .out_valid(vo4));
   full_adder #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .In1(a8), .In2(b8), .Cin(ci8), .in_valid(v8),
      .Sum(sum8), .Cout(co8), .Ovf(of8), .out_valid(vo8));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: integer sum for Sum/Cout, two's-complement range test for Ovf.
   function automatic logic [65:0] model(input int w, input longint a, input longint b, input bit ci);
      longint u, sa, sb, st, lim;
      logic   o, co;
      lim = longint'(1) << (w - 1);
      u   = a + b + longint'(ci);
      sa  = (a >= lim) ? a - 2 * lim : a;
      sb  = (b >= lim) ? b - 2 * lim : b;
      st  = sa + sb + longint'(ci);
      o   = (st >= lim) || (st < -lim);
      co  = ((u >> w) & 1) != 0;
      return {o, co, 64'(u & (2 * lim - 1))};
   endfunction

   logic [1:0]  tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
   logic [3:0]  d_a [4] = '{4'd15, 4'd15, 4'd7, 4'd8};
   logic [3:0]  d_b [4] = '{4'd0, 4'd15, 4'd1, 4'd8};
   logic        d_c [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [5:0]  d_e [4] = '{{4'd0, 2'b10}, {4'd15, 2'b10}, {4'd8, 2'b01}, {4'd0, 2'b11}};
   int          wd  [3] = '{1, 4, 8};
   logic [7:0]  ra [3], rb [3];
   bit          rc [3], rv [3];
   logic [65:0] er [3];
   logic [65:0] r;
   logic [63:0] g_s;
   logic        g_c, g_o, g_v;

   initial begin
      {a1, b1, ci1, v1, a4, b4, ci4, v4, a8, b8, ci8, v8} = '0;
      #1 rst = 1'b1;
      #1;
      chk("rst_sum1", sum1, 0);
      chk("rst_vo1", vo1, 0);
      chk("rst_sum4", sum4, 0);
      chk("rst_ovf4", of4, 0);
      chk("rst_sum8", sum8, 0);
      chk("rst_co8", co8, 0);
      tick;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         {a1, b1, ci1} = 3'(k);
         v1 = 1'b1;
         tick;
         r = model(1, longint'(k >> 2), longint'((k >> 1) & 1), bit'(k & 1));
         chk($sformatf("tt_%0d", k), {co1, sum1}, tt[k]);
         chk($sformatf("tt_ovf_%0d", k), of1, r[65]);
         chk($sformatf("tt_vo_%0d", k), vo1, 1);
      end
      {a1, b1, ci1} = 3'b111;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_sum", sum1, 0);
      chk("mid_rst_co", co1, 0);
      chk("mid_rst_vo", vo1, 0);
      {a1, b1, ci1} = 3'b010;
      tick;
      chk("rst_held_vo", vo1, 0);
      chk("rst_held_sum", sum1, 0);
      rst = 1'b0;
      tick;
      chk("post_rst_sum", sum1, 1);
      chk("post_rst_co", co1, 0);
      chk("post_rst_vo", vo1, 1);
      v1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a4 = d_a[k];
         b4 = d_b[k];
         ci4 = d_c[k];
         v4 = 1'b1;
         tick;
         chk($sformatf("w4_%0d_sum", k), sum4, d_e[k][5:2]);
         chk($sformatf("w4_%0d_co", k), co4, d_e[k][1]);
         chk($sformatf("w4_%0d_ovf", k), of4, d_e[k][0]);
      end
      a4 = 4'd3;
      b4 = 4'd4;
      ci4 = 1'b0;
      tick;
      chk("hold_cap_sum", sum4, 7);
      chk("hold_cap_vo", vo4, 1);
      v4 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            a4 = 'x;
            b4 = 'x;
            ci4 = 1'bx;
         end else begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            ci4 = 1'($urandom);
         end
         tick;
         chk($sformatf("hold_sum_%0d", k), sum4, 7);
         chk($sformatf("hold_co_%0d", k), co4, 0);
         chk($sformatf("hold_vo_%0d", k), vo4, 0);
      end
      a8 = 8'd200;
      b8 = 8'd100;
      ci8 = 1'b0;
      v8 = 1'b1;
      tick;
      chk("b2b0_sum", sum8, 44);
      chk("b2b0_co", co8, 1);
      chk("b2b0_vo", vo8, 1);
      a8 = 8'd1;
      b8 = 8'd1;
      ci8 = 1'b1;
      tick;
      chk("b2b1_sum", sum8, 3);
      chk("b2b1_co", co8, 0);
      chk("b2b1_vo", vo8, 1);
      for (int n = 0; n < 300; n++) begin
         for (int j = 0; j < 3; j++) begin
            ra[j] = 8'($urandom_range(0, (1 << wd[j]) - 1));
            rb[j] = 8'($urandom_range(0, (1 << wd[j]) - 1));
            rc[j] = 1'($urandom);
            rv[j] = (n == 0) ? 1'b1 : 1'($urandom);
         end
         a1 = ra[0][0:0]; b1 = rb[0][0:0]; ci1 = rc[0]; v1 = rv[0];
         a4 = ra[1][3:0]; b4 = rb[1][3:0]; ci4 = rc[1]; v4 = rv[1];
         a8 = ra[2];      b8 = rb[2];      ci8 = rc[2]; v8 = rv[2];
         tick;
         for (int j = 0; j < 3; j++) begin
            if (rv[j]) er[j] = model(wd[j], longint'(ra[j]), longint'(rb[j]), rc[j]);
            g_s = (j == 0) ? 64'(sum1) : (j == 1) ? 64'(sum4) : 64'(sum8);
            g_c = (j == 0) ? co1 : (j == 1) ? co4 : co8;
            g_o = (j == 0) ? of1 : (j == 1) ? of4 : of8;
            g_v = (j == 0) ? vo1 : (j == 1) ? vo4 : vo8;
            chk($sformatf("rnd_w%0d_sum_%0d", wd[j], n), g_s, er[j][63:0]);
            chk($sformatf("rnd_w%0d_co_%0d", wd[j], n), g_c, er[j][64]);
            chk($sformatf("rnd_w%0d_ovf_%0d", wd[j], n), g_o, er[j][65]);
            chk($sformatf("rnd_w%0d_vo_%0d", wd[j], n), g_v, rv[j]);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
